// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: single outstanding request,
// programmable wait states, byte-enable stores and misaligned/out-of-range error flagging.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            err_q;
    logic            ready_q;
    logic            resp_valid_q;
    logic [31:0]     rdata_q;
    logic            resp_err_q;
    logic            busy_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [29:0]     wofs_s;
    logic [AW-1:0]   req_idx_s;
    logic            req_err_s;
    logic            accept_s;
    logic [AW-1:0]   sel_idx_s;
    logic            sel_we_s;
    logic            sel_err_s;
    logic [31:0]     rdata_d;

    // Word offset from the base; BASE_ADDR is aligned so its low two bits drop out.
    assign wofs_s    = req_addr[31:2] - BASE_ADDR[31:2];
    assign req_idx_s = wofs_s[AW-1:0];
    assign req_err_s = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                       (wofs_s >= 30'(DEPTH_WORDS));
    assign accept_s  = req_valid && ready_q;

    // Read data for the response: from the live request when RESP follows accept directly.
    always_comb begin
        sel_idx_s = idx_q;
        sel_we_s  = we_q;
        sel_err_s = err_q;
        if (state_q == S_IDLE) begin
            sel_idx_s = req_idx_s;
            sel_we_s  = req_we;
            sel_err_s = req_err_s;
        end else begin
            sel_idx_s = idx_q;
            sel_we_s  = we_q;
            sel_err_s = err_q;
        end
        if (sel_we_s || sel_err_s) begin
            rdata_d = 32'd0;
        end else begin
            rdata_d = mem[sel_idx_s];
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        we_q    <= req_we;
                        idx_q   <= req_idx_s;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= req_err_s;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= rdata_d;
                            resp_err_q   <= req_err_s;
                        end else begin
                            cnt_q   <= 4'(WAIT_CYCLES);
                            state_q <= S_WAIT;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= rdata_d;
                        resp_err_q   <= err_q;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Store commits on the edge closing RESP, so a reset during the transaction suppresses it.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for functional checks
// and a WAIT_CYCLES=0 instance for back-to-back throughput and base-offset range checks.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        a_valid, a_ready, a_we, a_rv, a_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_valid, b_ready, b_we, b_rv, b_err, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int n_tests = 0;
    int n_fail  = 0;
    int resp_cnt_a = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .resp_valid(a_rv),
        .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .resp_valid(b_rv),
        .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy)
    );

    always @(negedge clk) begin
        if (a_rv) resp_cnt_a <= resp_cnt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on dut_a; optionally scrambles request inputs while it is in flight.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit wiggle, output logic [31:0] rd,
                       output logic er, output int lat, output logic bsy);
        int n;
        n = 0;
        a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        bsy = a_busy;
        while (!a_rv && lat < 50) begin
            if (wiggle) begin
                a_addr  = $urandom;
                a_wdata = $urandom;
                a_we    = ~a_we;
                a_be    = 4'($urandom_range(15, 0));
            end
            @(posedge clk); #1;
            lat++;
        end
        rd = a_rdata;
        er = a_err;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic exp_err);
        logic [31:0] rd; logic er; int lat; logic bsy;
        txn(1'b1, addr, wdata, be, 1'b0, rd, er, lat, bsy);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_rd"}, rd, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
        logic [31:0] rd; logic er; int lat; logic bsy;
        txn(1'b0, addr, 32'd0, 4'hF, 1'b0, rd, er, lat, bsy);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_rd"}, rd, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd; logic er; int lat; logic bsy;
        int rv_before, k, j, n;
        int acc_cyc[4];
        int rsp_cyc[4];
        logic rsp_err[4];
        logic [31:0] rsp_rd[4];
        logic [31:0] baddr[4];
        logic acc;

        rst_a = 1'b0; rst_b = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_be = 4'd0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_be = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_rv", 32'(a_rv), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Basic store/load with latency
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat, bsy);
        chk("st1_lat", 32'(lat), 32'd3);
        chk("st1_err", 32'(er), 32'd0);
        chk("st1_rd", rd, 32'd0);
        chk("st1_busy", 32'(bsy), 32'd1);
        txn(1'b0, 32'h10, 32'd0, 4'hF, 1'b0, rd, er, lat, bsy);
        chk("ld1_lat", 32'(lat), 32'd3);
        chk("ld1_err", 32'(er), 32'd0);
        chk("ld1_rd", rd, 32'hDEADBEEF);

        // Byte enables
        do_store("st2a", 32'h20, 32'h11223344, 4'hF, 1'b0);
        do_store("st2b", 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_load("ld2", 32'h20, 32'h11BB33DD, 1'b0);
        do_store("st2z", 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
        do_load("ld2z", 32'h20, 32'h11BB33DD, 1'b0);

        // Errors and range boundaries
        do_load("ld_mis", 32'h13, 32'd0, 1'b1);
        do_load("ld_oor", 32'h400, 32'd0, 1'b1);
        do_store("st_last", 32'h3FC, 32'h0BADF00D, 4'hF, 1'b0);
        do_load("ld_last", 32'h3FC, 32'h0BADF00D, 1'b0);
        do_store("st_w0", 32'h0, 32'h01020304, 4'hF, 1'b0);
        do_store("st_oor", 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1);
        do_store("st_402", 32'h402, 32'hFFFFFFFF, 4'hF, 1'b1);
        do_load("ld_w0", 32'h0, 32'h01020304, 1'b0);
        do_store("st_mis", 32'h22, 32'hFFFFFFFF, 4'hF, 1'b1);
        do_load("ld_w20", 32'h20, 32'h11BB33DD, 1'b0);

        // Reset during WAIT drops the store
        do_store("st5", 32'h40, 32'h12345678, 4'hF, 1'b0);
        a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'h55555555; a_be = 4'hF; a_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        rv_before = resp_cnt_a;
        @(negedge clk); #2;
        rst_a = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 32'(a_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("no_resp", 32'(resp_cnt_a), 32'(rv_before));
        do_load("ld5", 32'h40, 32'h12345678, 1'b0);

        // Inputs scrambled in flight are ignored
        txn(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, lat, bsy);
        chk("st6_lat", 32'(lat), 32'd3);
        chk("st6_err", 32'(er), 32'd0);
        do_load("ld6", 32'h80, 32'hCAFEF00D, 1'b0);
        txn(1'b0, 32'h10, 32'd0, 4'hF, 1'b1, rd, er, lat, bsy);
        chk("ld6w_rd", rd, 32'hDEADBEEF);
        chk("ld6w_err", 32'(er), 32'd0);

        // Zero-wait back-to-back loads on dut_b
        baddr[0] = 32'h1000; baddr[1] = 32'h1004; baddr[2] = 32'h0FFC; baddr[3] = 32'h1040;
        for (int i = 0; i < 4; i++) begin
            acc_cyc[i] = -1; rsp_cyc[i] = -1; rsp_err[i] = 1'b0; rsp_rd[i] = 32'hFFFFFFFF;
        end
        k = 0; j = 0; n = 0;
        @(negedge clk);
        while (!b_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        b_addr = baddr[0]; b_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            acc = b_valid && b_ready;
            if (acc && k < 4) begin
                acc_cyc[k] = c;
                k++;
            end
            if (b_rv && j < 4) begin
                rsp_cyc[j] = c; rsp_err[j] = b_err; rsp_rd[j] = b_rdata;
                j++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (k < 4) b_addr = baddr[k];
                else b_valid = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_acc%0d", i), acc_cyc[i], 32'(2 * i));
            chk($sformatf("b_rsp%0d", i), rsp_cyc[i], 32'(2 * i + 1));
        end
        chk("b_err0", 32'(rsp_err[0]), 32'd0);
        chk("b_err1", 32'(rsp_err[1]), 32'd0);
        chk("b_err_below", 32'(rsp_err[2]), 32'd1);
        chk("b_err_above", 32'(rsp_err[3]), 32'd1);
        chk("b_rd_below", rsp_rd[2], 32'd0);
        chk("b_rd_above", rsp_rd[3], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the MIPS core's load/store port: the core initiates, this block accepts one request at a time and responds.
- Inserts a programmable number of wait states so the core's stall logic is exercised in simulation.
- Holds a word-addressed storage array with byte-enable writes and flags misaligned or out-of-range accesses.
- Sits beside the core in the top-level simulation harness, clocked from the harness clock.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in storage; power of two, at least 4
WAIT_CYCLES, 2, wait states between request accept and response; 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
req_valid  in  1  core presents a request
req_ready  out  1  responder can accept; a request is accepted on a cycle with req_valid=1 and req_ready=1
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables; bit i selects wdata[8i+7:8i]
resp_valid  out  1  one-cycle pulse, response present
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid: misaligned or out-of-range
busy  out  1  high from accept until the cycle after the resp_valid pulse

Behaviour:
- Reset (rst=0): FSM→IDLE; req_ready=0 while in reset; resp_valid=0, resp_rdata=0, resp_err=0, busy=0; wait counter=0. Storage contents are not cleared.
- States:
  - IDLE: req_ready=1. On accept, latch we/addr/wdata/be and evaluate the error condition. If WAIT_CYCLES=0 go to RESP, else load counter=WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready=0; counter decrements each cycle; go to RESP when counter reaches 1.
  - RESP: req_ready=0; resp_valid=1 for exactly this cycle; go to IDLE next cycle.
- Latency: accept edge to resp_valid = WAIT_CYCLES+1 cycles. The next accept is possible the cycle after RESP.
- Error conditions:
  - misaligned: addr[1:0]≠0.
  - out of range: (addr−BASE_ADDR)>>2 ≥ DEPTH_WORDS, or addr<BASE_ADDR.
  - On error: store performs no write; response has resp_err=1, resp_rdata=0.
- Store: write occurs on the RESP cycle edge. Only lanes with be=1 are written; be=0000 is a legal no-op with err=0. resp_rdata=0.
- Load: resp_rdata is the full word read at RESP. be is ignored on loads.
- Read-after-write: a load accepted after a store's RESP returns the stored data. No bypass is needed, since requests never overlap.
- Request inputs are sampled only at accept. Changes while in WAIT or RESP are ignored.
- A req_valid held high through RESP is accepted in the following IDLE cycle. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Reset mid-transaction: the in-flight request is dropped, no resp_valid is issued, and no write occurs if reset asserts before the RESP edge.
- Outputs are registered; resp_rdata holds its value until the next RESP.

Test Plan:
1. Reset, then with WAIT_CYCLES=2 store 0xDEADBEEF, be=1111 to 0x10, then load 0x10 → resp_valid 3 cycles after each accept; load returns 0xDEADBEEF, err=0.
2. Word 0x20=0x11223344; store 0xAABBCCDD with be=0101; load → 0x11BB33DD.
3. Load from 0x13 (misaligned) and from BASE_ADDR+DEPTH_WORDS*4 → err=1, rdata=0. A store to 0x402 with be=1111 leaves word 0x400>>2 unchanged when read back.
4. WAIT_CYCLES=0 build: hold req_valid high for 4 loads → accepts on cycles 0, 2, 4, 6; resp_valid on cycles 1, 3, 5, 7.
5. Accept a store, drive rst=0 asynchronously during WAIT, release → no resp_valid; target word is unchanged; req_ready=1 on the first clock after release.
6. Change req_addr and req_wdata every cycle during WAIT → response reflects only the values latched at accept.
